gdma_rd_engine: RTL and testbench

//  Parametrised AXI4 read-DMA channel: reads a linear DDR region and streams it out as AXI-Stream.

---
 rtl/gdma_rd_engine.sv | 200 ++++++++++++++++++++
 tb/tb_gdma_rd_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gdma_rd_engine.sv
// gdma_rd_engine: AXI4 read-DMA channel that walks a linear DDR region and
// streams it out as AXI-Stream with per-packet tlast.
// Bursts are sized so that none crosses a 4 KB boundary.
// At most MAX_OUTST bursts are in flight, and the stream can be throttled to one beat per N cycles.
// Optional feature macro: GDMA_RD_RRESP_ERR_EN adds a sticky rd_err output
// that flags any beat returned with a non-OKAY rresp.
module gdma_rd_engine #(
  parameter int ADDR_W    = 49,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int MAX_OUTST = 4
) (
  input  logic              gdma_clk,
  input  logic              gdma_rst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       length,
  input  logic [15:0]       pkt_beats,
  input  logic [31:0]       gdma_speed_divider,
  input  logic              gdma_start,
  output logic              gdma_busy,
  output logic              gdma_done,
  output logic [ADDR_W-1:0] ddr_araddr,
  output logic [7:0]        ddr_arlen,
  output logic [2:0]        ddr_arsize,
  output logic [1:0]        ddr_arburst,
  output logic [3:0]        ddr_arcache,
  output logic              ddr_arvalid,
  input  logic              ddr_arready,
  input  logic [DATA_W-1:0] ddr_rdata,
  input  logic [1:0]        ddr_rresp,
  input  logic              ddr_rlast,
  input  logic              ddr_rvalid,
  output logic              ddr_rready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
`ifdef GDMA_RD_RRESP_ERR_EN
  ,
  output logic              rd_err
`endif
);

  localparam int          BPB         = DATA_W / 8;
  localparam int          BPB_LOG2    = $clog2(BPB);
  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [4:0]  MAX_OUTST_W = 5'(MAX_OUTST);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       ar_left_q;
  logic [31:0]       rx_left_q;
  logic [15:0]       pkt_q;
  logic [15:0]       pkt_cnt_q;
  logic [4:0]        outst_q;
  logic [31:0]       thr_cnt_q;
  logic              done_q;

  logic [31:0] start_beats;
  logic        start_acc;
  logic [12:0] bytes_to_4k;
  logic [31:0] beats_to_4k;
  logic [31:0] burst_beats;
  logic        ar_hs;
  logic        r_hs;
  logic        final_beat;
  logic        throttle_en;
  logic        slot;
  logic        pkt_edge;

  assign start_beats = length >> BPB_LOG2;
  assign start_acc   = gdma_start & (state_q == ST_IDLE);
  assign ar_hs       = ddr_arvalid & ddr_arready;
  assign r_hs        = ddr_rvalid & ddr_rready;
  assign final_beat  = r_hs & (rx_left_q == 32'd1);
  assign throttle_en = gdma_speed_divider > 32'd1;
  assign slot        = ~throttle_en | (thr_cnt_q == 32'd0);
  assign pkt_edge    = (pkt_q != 16'd0) & (pkt_cnt_q == pkt_q - 16'd1);

  assign gdma_busy   = (state_q != ST_IDLE);
  assign gdma_done   = done_q;

  assign ddr_araddr  = addr_q;
  assign ddr_arlen   = (state_q == ST_ISSUE) ? 8'(burst_beats - 32'd1) : 8'd0;
  assign ddr_arsize  = 3'(BPB_LOG2);
  assign ddr_arburst = 2'b01;
  assign ddr_arcache = 4'b0011;
  assign ddr_arvalid = (state_q == ST_ISSUE) & (outst_q < MAX_OUTST_W);

  assign m_tdata     = ddr_rdata;
  assign m_tvalid    = ddr_rvalid & slot & gdma_busy;
  assign ddr_rready  = m_tready & slot & gdma_busy;
  assign m_tlast     = m_tvalid & ((rx_left_q == 32'd1) | pkt_edge);

  // Next burst length: the smallest of the burst cap, the beats still to request and the room left in this 4 KB page
  always_comb begin
    bytes_to_4k = 13'd4096 - {1'b0, addr_q[11:0]};
    beats_to_4k = 32'(bytes_to_4k >> BPB_LOG2);
    burst_beats = MAX_BURST_W;
    if (ar_left_q < burst_beats) burst_beats = ar_left_q;
    if (beats_to_4k < burst_beats) burst_beats = beats_to_4k;
  end

  // AR sequencing: latch the job on start, then advance the address per AR handshake until every beat is requested
  always_ff @(posedge gdma_clk) begin
    if (gdma_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ar_left_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            addr_q    <= start_addr;
            ar_left_q <= start_beats;
            if (start_beats == 32'd0) done_q <= 1'b1;
            else state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ar_hs) begin
            addr_q    <= addr_q + (ADDR_W'(burst_beats) << BPB_LOG2);
            ar_left_q <= ar_left_q - burst_beats;
            if (ar_left_q == burst_beats) state_q <= ST_WAIT_R;
          end
        end
        default: ;
      endcase
      if (final_beat) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b1;
      end
    end
  end

  // Beat bookkeeping: beats still expected and the position inside the current packet
  always_ff @(posedge gdma_clk) begin
    if (gdma_rst) begin
      rx_left_q <= 32'd0;
      pkt_q     <= 16'd0;
      pkt_cnt_q <= 16'd0;
    end else if (start_acc) begin
      rx_left_q <= start_beats;
      pkt_q     <= pkt_beats;
      pkt_cnt_q <= 16'd0;
    end else if (r_hs) begin
      rx_left_q <= rx_left_q - 32'd1;
      pkt_cnt_q <= pkt_edge ? 16'd0 : pkt_cnt_q + 16'd1;
    end
  end

  // Bursts in flight: up on AR handshake, down on the rlast beat, unchanged when both happen together
  always_ff @(posedge gdma_clk) begin
    if (gdma_rst) begin
      outst_q <= 5'd0;
    end else begin
      case ({ar_hs, r_hs & ddr_rlast})
        2'b10:   outst_q <= outst_q + 5'd1;
        2'b01:   outst_q <= outst_q - 5'd1;
        default: ;
      endcase
    end
  end

  // Throttle: slot opens at count 0 and stays open until a beat moves, then the count restarts from 1
  always_ff @(posedge gdma_clk) begin
    if (gdma_rst || !gdma_busy || !throttle_en) begin
      thr_cnt_q <= 32'd0;
    end else if (thr_cnt_q == 32'd0) begin
      if (r_hs) thr_cnt_q <= 32'd1;
    end else if (thr_cnt_q >= gdma_speed_divider - 32'd1) begin
      thr_cnt_q <= 32'd0;
    end else begin
      thr_cnt_q <= thr_cnt_q + 32'd1;
    end
  end

`ifdef GDMA_RD_RRESP_ERR_EN
  // Sticky read-error flag, cleared by an accepted start; the transfer itself carries on regardless
  always_ff @(posedge gdma_clk) begin
    if (gdma_rst) begin
      rd_err <= 1'b0;
    end else if (start_acc) begin
      rd_err <= 1'b0;
    end else if (r_hs && (ddr_rresp != 2'b00)) begin
      rd_err <= 1'b1;
    end
  end
`else
  logic rresp_unused;
  assign rresp_unused = ^ddr_rresp;
`endif

endmodule

// File: tb/tb_gdma_rd_engine.sv
// tb_gdma_rd_engine: directed and randomized transfers against a DDR
// responder and a stream monitor; expectations come from a page-splitting
// burst model and an address-keyed data pattern.
// GDMA_RD_RRESP_ERR_EN, when defined, also exercises the rd_err output.
module tb_gdma_rd_engine;

  localparam int ADDR_W    = 49;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 256;
  localparam int MAX_OUTST = 2;
  localparam int BPB       = DATA_W / 8;

  logic              gdma_clk;
  logic              gdma_rst;
  logic [ADDR_W-1:0] start_addr;
  logic [31:0]       length;
  logic [15:0]       pkt_beats;
  logic [31:0]       gdma_speed_divider;
  logic              gdma_start;
  logic              gdma_busy;
  logic              gdma_done;
  logic [ADDR_W-1:0] ddr_araddr;
  logic [7:0]        ddr_arlen;
  logic [2:0]        ddr_arsize;
  logic [1:0]        ddr_arburst;
  logic [3:0]        ddr_arcache;
  logic              ddr_arvalid;
  logic              ddr_arready;
  logic [DATA_W-1:0] ddr_rdata;
  logic [1:0]        ddr_rresp;
  logic              ddr_rlast;
  logic              ddr_rvalid;
  logic              ddr_rready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
`ifdef GDMA_RD_RRESP_ERR_EN
  logic              rd_err;
`endif

  gdma_rd_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .gdma_clk(gdma_clk), .gdma_rst(gdma_rst),
    .start_addr(start_addr), .length(length), .pkt_beats(pkt_beats),
    .gdma_speed_divider(gdma_speed_divider), .gdma_start(gdma_start),
    .gdma_busy(gdma_busy), .gdma_done(gdma_done),
    .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen), .ddr_arsize(ddr_arsize),
    .ddr_arburst(ddr_arburst), .ddr_arcache(ddr_arcache),
    .ddr_arvalid(ddr_arvalid), .ddr_arready(ddr_arready),
    .ddr_rdata(ddr_rdata), .ddr_rresp(ddr_rresp), .ddr_rlast(ddr_rlast),
    .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef GDMA_RD_RRESP_ERR_EN
    , .rd_err(rd_err)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          len;
  } burst_t;

  int checks   = 0;
  int failures = 0;

  // responder knobs and state
  bit     ar_rand, r_rand, t_rand, hold_r;
  int     err_beat;
  int     r_served;
  int     beat_idx;
  bit     r_moved, flush_r;
  burst_t pend_q[$];

  // monitor records
  logic [63:0] obs_ar_addr[$];
  int          obs_ar_len[$];
  logic [31:0] obs_data[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  int          cyc, done_cnt, done_cyc, start_cyc, arvalid_cycles;
  logic [2:0]  seen_arsize;
  logic [1:0]  seen_arburst;
  logic [3:0]  seen_arcache;

  initial begin
    gdma_clk = 1'b0;
    forever #5 gdma_clk = ~gdma_clk;
  end

  // Memory contents are a fixed scramble of the byte address
  function automatic logic [31:0] data_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // DDR responder and monitor: drive on the falling edge, sample 1 ns before the rising edge
  initial begin
    ddr_arready = 1'b0; ddr_rvalid = 1'b0; ddr_rdata = '0; ddr_rresp = 2'b00;
    ddr_rlast = 1'b0; m_tready = 1'b0;
    cyc = 0; beat_idx = 0; r_moved = 0; flush_r = 0;
    forever begin
      @(negedge gdma_clk);
      ddr_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready    = t_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_moved || flush_r) begin
        ddr_rvalid = 1'b0; ddr_rlast = 1'b0; ddr_rresp = 2'b00;
        r_moved = 0; flush_r = 0;
      end
      if (!ddr_rvalid && pend_q.size() > 0 && !hold_r && !(r_rand && $urandom_range(0, 2) == 0)) begin
        ddr_rvalid = 1'b1;
        ddr_rdata  = data_of(pend_q[0].addr + 64'(beat_idx * BPB));
        ddr_rlast  = (beat_idx == pend_q[0].len);
        ddr_rresp  = (r_served == err_beat) ? 2'b10 : 2'b00;
      end
      #4;
      cyc++;
      if (gdma_rst) begin
        pend_q.delete();
        beat_idx = 0;
        flush_r  = 1;
      end else begin
        if (gdma_start && !gdma_busy) start_cyc = cyc;
        if (gdma_done) begin done_cnt++; done_cyc = cyc; end
        if (ddr_arvalid) arvalid_cycles++;
        if (ddr_arvalid && ddr_arready) begin
          obs_ar_addr.push_back(64'(ddr_araddr));
          obs_ar_len.push_back(int'(ddr_arlen));
          pend_q.push_back('{64'(ddr_araddr), int'(ddr_arlen)});
          seen_arsize = ddr_arsize; seen_arburst = ddr_arburst; seen_arcache = ddr_arcache;
        end
        if (m_tvalid && m_tready) begin
          obs_data.push_back(m_tdata);
          obs_last.push_back(m_tlast);
          obs_cyc.push_back(cyc);
        end
        if (ddr_rvalid && ddr_rready && pend_q.size() > 0) begin
          r_served++;
          r_moved = 1;
          if (beat_idx == pend_q[0].len) begin
            void'(pend_q.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  // Launch one transfer with a single-cycle start pulse
  task automatic applyStimulus(input logic [63:0] a, input int len, input int pkt, input int div);
    obs_ar_addr.delete(); obs_ar_len.delete();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_cnt = 0; arvalid_cycles = 0; r_served = 0;
    start_addr         = ADDR_W'(a);
    length             = 32'(len);
    pkt_beats          = 16'(pkt);
    gdma_speed_divider = 32'(div);
    gdma_start         = 1'b1;
    @(negedge gdma_clk);
    gdma_start         = 1'b0;
  endtask

  // Wait for completion, then compare everything seen against the reference model
  task automatic finishTransfer(input logic [63:0] a, input int len, input int pkt,
                                input int interval, input int budget);
    logic [63:0] exp_addr[$];
    int          exp_len[$];
    logic [63:0] m_addr;
    int          rem, to4k, b, n, waited, bad_data, bad_last, bad_gap;
    bit          exp_last;
    waited = 0;
    while (done_cnt == 0 && waited < budget) begin
      @(negedge gdma_clk);
      waited++;
    end
    checkOutput("done_within_budget", 64'(done_cnt != 0), 64'd1);
    repeat (4) @(negedge gdma_clk);
    checkOutput("done_once", 64'(done_cnt), 64'd1);
    checkOutput("busy_after_done", 64'(gdma_busy), 64'd0);

    m_addr = a;
    rem    = len / BPB;
    while (rem > 0) begin
      to4k = (4096 - int'(m_addr % 64'd4096)) / BPB;
      b = MAX_BURST;
      if (rem < b) b = rem;
      if (to4k < b) b = to4k;
      exp_addr.push_back(m_addr);
      exp_len.push_back(b - 1);
      m_addr += 64'(b * BPB);
      rem    -= b;
    end
    checkOutput("ar_count", 64'(obs_ar_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_ar_addr.size(); i++) begin
      checkOutput($sformatf("ar%0d_addr", i), obs_ar_addr[i], exp_addr[i]);
      checkOutput($sformatf("ar%0d_len", i), 64'(obs_ar_len[i]), 64'(exp_len[i]));
    end

    n = len / BPB;
    bad_data = 0; bad_last = 0; bad_gap = 0;
    for (int i = 0; i < obs_data.size(); i++) begin
      exp_last = ((i + 1) == n) || (pkt != 0 && ((i + 1) % pkt) == 0);
      if (obs_data[i] !== data_of(a + 64'(i * BPB))) bad_data++;
      if (obs_last[i] !== exp_last) bad_last++;
      if (interval > 0 && i > 0 && (obs_cyc[i] - obs_cyc[i-1]) != interval) bad_gap++;
    end
    checkOutput("beat_count", 64'(obs_data.size()), 64'(n));
    checkOutput("bad_data_beats", 64'(bad_data), 64'd0);
    checkOutput("bad_tlast_beats", 64'(bad_last), 64'd0);
    if (interval > 0) checkOutput("bad_beat_spacing", 64'(bad_gap), 64'd0);
    if (obs_cyc.size() > 0) begin
      checkOutput("done_after_last_beat", 64'(done_cyc - obs_cyc[obs_cyc.size()-1]), 64'd1);
    end else begin
      checkOutput("done_after_start", 64'(done_cyc - start_cyc), 64'd1);
      checkOutput("arvalid_cycles", 64'(arvalid_cycles), 64'd0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},    64'(gdma_busy),   64'd0);
    checkOutput({tag, "_done"},    64'(gdma_done),   64'd0);
    checkOutput({tag, "_arvalid"}, 64'(ddr_arvalid), 64'd0);
    checkOutput({tag, "_araddr"},  64'(ddr_araddr),  64'd0);
    checkOutput({tag, "_arlen"},   64'(ddr_arlen),   64'd0);
    checkOutput({tag, "_rready"},  64'(ddr_rready),  64'd0);
    checkOutput({tag, "_tvalid"},  64'(m_tvalid),    64'd0);
    checkOutput({tag, "_tlast"},   64'(m_tlast),     64'd0);
  endtask

  // Directed scenarios followed by randomized transfers
  initial begin
    gdma_rst = 1'b1; gdma_start = 1'b0; start_addr = '0; length = 32'd0;
    pkt_beats = 16'd0; gdma_speed_divider = 32'd0;
    ar_rand = 0; r_rand = 0; t_rand = 0; hold_r = 0; err_beat = -1; r_served = 0;
    done_cnt = 0; done_cyc = 0; start_cyc = 0; arvalid_cycles = 0;
    repeat (3) @(negedge gdma_clk);
    checkIdle("reset");
    gdma_rst = 1'b0;
    @(negedge gdma_clk);

    $display("[TB] full 4 KB page, tlast on final beat only");
    applyStimulus(64'h1000, 4096, 0, 0);
    finishTransfer(64'h1000, 4096, 0, 0, 5000);

    $display("[TB] burst split at 4 KB boundary");
    applyStimulus(64'h0FF0, 64, 0, 0);
    finishTransfer(64'h0FF0, 64, 0, 0, 500);
    checkOutput("arsize", 64'(seen_arsize), 64'd2);
    checkOutput("arburst", 64'(seen_arburst), 64'd1);
    checkOutput("arcache", 64'(seen_arcache), 64'd3);

    $display("[TB] outstanding limit with read data withheld");
    hold_r = 1;
    applyStimulus(64'h0, 4096, 0, 0);
    repeat (30) @(negedge gdma_clk);
    checkOutput("stall_ar_count", 64'(obs_ar_addr.size()), 64'(MAX_OUTST));
    checkOutput("stall_beats", 64'(obs_data.size()), 64'd0);
    hold_r = 0;
    finishTransfer(64'h0, 4096, 0, 0, 5000);

    $display("[TB] divider 4 with 3-beat packets");
    applyStimulus(64'h2000, 40, 3, 4);
    finishTransfer(64'h2000, 40, 3, 4, 500);

    $display("[TB] zero length");
    applyStimulus(64'h5000, 0, 0, 0);
    finishTransfer(64'h5000, 0, 0, 0, 50);

    $display("[TB] start while busy is ignored");
    applyStimulus(64'h6000, 512, 7, 0);
    repeat (10) @(negedge gdma_clk);
    start_addr = ADDR_W'(64'h9000); length = 32'd64; pkt_beats = 16'd2;
    gdma_start = 1'b1;
    @(negedge gdma_clk);
    gdma_start = 1'b0;
    finishTransfer(64'h6000, 512, 7, 0, 1000);

    $display("[TB] reset in the middle of a transfer");
    applyStimulus(64'h3000, 2048, 0, 0);
    repeat (40) @(negedge gdma_clk);
    gdma_rst = 1'b1;
    @(negedge gdma_clk);
    checkIdle("midrst");
    gdma_rst = 1'b0;
    @(negedge gdma_clk);
    applyStimulus(64'h3000, 256, 5, 2);
    finishTransfer(64'h3000, 256, 5, 0, 1000);

`ifdef GDMA_RD_RRESP_ERR_EN
    $display("[TB] sticky read error");
    err_beat = 5;
    applyStimulus(64'h7000, 256, 0, 0);
    finishTransfer(64'h7000, 256, 0, 0, 1000);
    checkOutput("rd_err_set", 64'(rd_err), 64'd1);
    repeat (5) @(negedge gdma_clk);
    checkOutput("rd_err_held", 64'(rd_err), 64'd1);
    err_beat = -1;
    applyStimulus(64'h7400, 128, 0, 0);
    checkOutput("rd_err_cleared", 64'(rd_err), 64'd0);
    finishTransfer(64'h7400, 128, 0, 0, 1000);
    checkOutput("rd_err_clean", 64'(rd_err), 64'd0);
`endif

    $display("[TB] randomized transfers");
    ar_rand = 1; r_rand = 1; t_rand = 1;
    for (int k = 0; k < 6; k++) begin
      logic [63:0] ra;
      int rl, rp, rd;
      ra = 64'(k) * 64'h10000 + 64'($urandom_range(0, 4095)) * 64'(BPB);
      rl = BPB * int'($urandom_range(0, 300));
      rp = int'($urandom_range(0, 12));
      rd = int'($urandom_range(0, 3));
      applyStimulus(ra, rl, rp, rd);
      finishTransfer(ra, rl, rp, 0, 20000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
